// File: rtl/otp_ctrl_pkg.sv
// otp_ctrl_pkg: shared types for the OTP partition check responder.
package otp_ctrl_pkg;
  typedef enum logic [3:0] {
    On  = 4'b0101,
    Off = 4'b1010
  } lc_tx_t;
  function automatic logic lc_tx_test_true_loose(input lc_tx_t v);
    return v != Off;
  endfunction
  // Every pair of states differs in at least three bits.
  typedef enum logic [5:0] {
    IdleSt      = 6'b101100,
    IntegSt     = 6'b010110,
    CnstyReqSt  = 6'b110001,
    CnstyWaitSt = 6'b001011,
    AckSt       = 6'b111111,
    ErrorSt     = 6'b000000
  } chk_resp_state_e;
  typedef enum logic {
    ChkInteg = 1'b0,
    ChkCnsty = 1'b1
  } chk_kind_e;
  localparam int unsigned ChkFoldRot = 1;
  function automatic logic [31:0] chk_fold(input logic [31:0] acc, input logic [31:0] w);
    return ((acc << ChkFoldRot) | (acc >> (32 - ChkFoldRot))) ^ w;
  endfunction
endpackage

// File: rtl/prim_count.sv
// prim_count: up counter with an inverted shadow copy; err_o flags any divergence.
module prim_count #(
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             incr_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);
  logic [Width-1:0] cnt_q, cnt_inv_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      cnt_inv_q <= '1;
    end else begin
      cnt_q     <= clr_i ? '0 : incr_i ? cnt_q + 1'b1 : cnt_q;
      cnt_inv_q <= clr_i ? '1 : incr_i ? cnt_inv_q - 1'b1 : cnt_inv_q;
    end
  end
  assign cnt_o = cnt_q;
  assign err_o = cnt_q != ~cnt_inv_q;
endmodule

// File: rtl/otp_ctrl_chk_responder.sv
// otp_ctrl_chk_responder: answers periodic integrity/consistency check requests for a partition.
// OTP_CTRL_CHK_RESP_CNT_REDUN_EN selects a redundant prim_count for the word index.
module otp_ctrl_chk_responder
  import otp_ctrl_pkg::*;
#(
  parameter int NumWords     = 8,
  parameter int OtpAddrWidth = 11,
  parameter int BaseAddr     = 0,
  localparam int IdxW        = $clog2(NumWords)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    integ_chk_req_i,
  input  logic                    cnsty_chk_req_i,
  output logic                    integ_chk_ack_o,
  output logic                    cnsty_chk_ack_o,
  output logic [IdxW-1:0]         buf_addr_o,
  input  logic [31:0]             buf_rdata_i,
  input  logic [31:0]             digest_i,
  output logic                    otp_req_o,
  output logic [OtpAddrWidth-1:0] otp_addr_o,
  input  logic                    otp_gnt_i,
  input  logic                    otp_rvalid_i,
  input  logic [31:0]             otp_rdata_i,
  input  logic                    otp_err_i,
  input  lc_tx_t                  escalate_en_i,
  output logic                    chk_busy_o,
  output logic                    integ_err_o,
  output logic                    cnsty_err_o,
  output logic                    fsm_err_o
);
  chk_resp_state_e state_q, state_d;
  chk_kind_e kind_q, kind_d;
  logic [31:0] acc_q, acc_d;
  logic [IdxW-1:0] idx;
  logic idx_clr, idx_incr, cnt_err, last;
  logic integ_err_q, cnsty_err_q, integ_err_set, cnsty_err_set;
  assign last = idx == IdxW'(NumWords - 1);
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    acc_d         = acc_q;
    idx_clr       = 1'b0;
    idx_incr      = 1'b0;
    integ_err_set = 1'b0;
    cnsty_err_set = 1'b0;
    unique case (state_q)
      IdleSt: begin
        if (integ_chk_req_i) begin
          state_d = IntegSt;
          kind_d  = ChkInteg;
          acc_d   = '0;
          idx_clr = 1'b1;
        end else if (cnsty_chk_req_i) begin
          state_d = CnstyReqSt;
          kind_d  = ChkCnsty;
          idx_clr = 1'b1;
        end
      end
      IntegSt: begin
        acc_d         = chk_fold(acc_q, buf_rdata_i);
        idx_incr      = !last;
        integ_err_set = last && acc_d != digest_i;
        state_d       = last ? AckSt : IntegSt;
      end
      CnstyReqSt: state_d = otp_gnt_i ? CnstyWaitSt : CnstyReqSt;
      CnstyWaitSt: begin
        if (otp_rvalid_i) begin
          if (otp_err_i) begin
            cnsty_err_set = 1'b1;
            state_d       = ErrorSt;
          end else begin
            cnsty_err_set = otp_rdata_i != buf_rdata_i;
            idx_incr      = !last;
            state_d       = last ? AckSt : CnstyReqSt;
          end
        end
      end
      AckSt:   state_d = IdleSt;
      ErrorSt: state_d = ErrorSt;
      default: state_d = ErrorSt;
    endcase
    // Escalation and index corruption win over every transition, including the ack.
    if (lc_tx_test_true_loose(escalate_en_i) || cnt_err) state_d = ErrorSt;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IdleSt;
      kind_q      <= ChkInteg;
      acc_q       <= '0;
      integ_err_q <= 1'b0;
      cnsty_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      acc_q       <= acc_d;
      integ_err_q <= integ_err_q | integ_err_set;
      cnsty_err_q <= cnsty_err_q | cnsty_err_set;
    end
  end
`ifdef OTP_CTRL_CHK_RESP_CNT_REDUN_EN
  prim_count #(
    .Width(IdxW)
  ) u_prim_count_idx (
    .clk_i,
    .rst_ni,
    .clr_i (idx_clr),
    .incr_i(idx_incr),
    .cnt_o (idx),
    .err_o (cnt_err)
  );
`else
  logic [IdxW-1:0] idx_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idx_q <= '0;
    else idx_q <= idx_clr ? '0 : idx_incr ? idx_q + 1'b1 : idx_q;
  end
  assign idx     = idx_q;
  assign cnt_err = 1'b0;
`endif
  assign integ_chk_ack_o = state_q == AckSt && kind_q == ChkInteg;
  assign cnsty_chk_ack_o = state_q == AckSt && kind_q == ChkCnsty;
  assign buf_addr_o      = idx;
  assign otp_req_o       = state_q == CnstyReqSt;
  assign otp_addr_o      = OtpAddrWidth'(BaseAddr) + OtpAddrWidth'(idx);
  assign chk_busy_o      = state_q == IntegSt || state_q == CnstyReqSt ||
                           state_q == CnstyWaitSt || state_q == AckSt;
  assign integ_err_o     = integ_err_q;
  assign cnsty_err_o     = cnsty_err_q;
  assign fsm_err_o       = state_q == ErrorSt;
endmodule
